// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives data/valid. The transmitter returns ready and busy.
interface uart_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;

  modport master (output data, output valid, input ready, input busy);
  modport slave  (input data, input valid, output ready, output busy);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, idle-high line, one byte per valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit (8E1).
module uart_tx #(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned BAUDRATE = 230_400
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_tx_if.slave    bus,
  output logic        tx
);

  localparam int unsigned DIV    = CLK_FREQ / BAUDRATE;
  localparam int unsigned CNT_W  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_tx: CLK_FREQ/BAUDRATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic [DATA_W-1:0]   shift, shift_next;
  logic                tx_next;
  logic                ready_next;
  logic                bit_end_c;
`ifdef UART_TX_PARITY_EN
  logic                par, par_next;
`endif

  assign bit_end_c = (cnt == CNT_W'(DIV - 1));

  // State and datapath registers; tx is forced high asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      tx        <= 1'b1;
      bus.ready <= 1'b1;
      bus.busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shift     <= shift_next;
      tx        <= tx_next;
      bus.ready <= ready_next;
      bus.busy  <= !ready_next;
`ifdef UART_TX_PARITY_EN
      par       <= par_next;
`endif
    end
  end

  // Next-state logic. tx_next is the line level for the state being entered,
  // so each bit appears on the registered pin at the edge that starts it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    tx_next    = tx;
    ready_next = bus.ready;
`ifdef UART_TX_PARITY_EN
    par_next   = par;
`endif

    if (state != S_IDLE) begin
      cnt_next = bit_end_c ? '0 : cnt + CNT_W'(1);
    end

    case (state)
      S_IDLE: begin
        tx_next    = 1'b1;
        ready_next = 1'b1;
        if (bus.valid && bus.ready) begin
          shift_next = bus.data;
          cnt_next   = '0;
          idx_next   = '0;
          state_next = S_START;
          tx_next    = 1'b0;
          ready_next = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_next   = ^bus.data;
`endif
        end
      end

      S_START: begin
        if (bit_end_c) begin
          state_next = S_DATA;
          tx_next    = shift[0];
        end
      end

      S_DATA: begin
        if (bit_end_c) begin
          if (idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
            tx_next    = par;
`else
            state_next = S_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            shift_next = shift >> 1;
            idx_next   = idx + IDX_W'(1);
            tx_next    = shift[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_c) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_end_c) begin
          state_next = S_IDLE;
          tx_next    = 1'b1;
          ready_next = 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        tx_next    = 1'b1;
        ready_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, reset corner cases and random bytes
// checked against a slot-level line model. Honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int unsigned CLK_FREQ = 12_000_000;
  localparam int unsigned BAUDRATE = 230_400;
  localparam int DIV = 52;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FR = NBITS * DIV;

  logic clk = 1'b0;
  logic rst_n;
  logic tx;
  uart_tx_if bus();

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_bad = 0;
  int last_e = 0;
  bit last_held = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // busy must always be the complement of ready
  always @(negedge clk) if (bus.busy !== !bus.ready) busy_bad++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Line model: slot 0 start, slots 1..8 data LSB first, optional even parity, then stop.
  function automatic logic [10:0] line_frame(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  // Called just after a negedge. Waits for the accept edge, then checks every cycle of the frame.
  task automatic run_frame(input logic [10:0] exp, input logic [7:0] exp_byte, input bit drop,
                           input logic [7:0] next_data, input bit mid_pulse, input string name);
    bit ok;
    int e;
    int bad[11];
    int rbad;
    int idle_bad;
    logic [7:0] rx;
    ok = 1'b0;
    for (int t = 0; t < 4 * FR; t++) begin
      if (bus.valid && bus.ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("%s accept", name), int'(ok), 1);
    if (!ok) return;
    e = cyc;
    if (last_held) check($sformatf("%s accept spacing", name), e - last_e, FR + 1);
    last_e = e;
    last_held = !drop;
    for (int b = 0; b < 11; b++) bad[b] = 0;
    rbad = 0;
    rx = '0;
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      if (k == 0 && drop) bus.valid = 1'b0;
      if (k == 1) bus.data = next_data;
      if (mid_pulse && k == 3 * DIV) bus.valid = 1'b1;
      if (mid_pulse && k == 3 * DIV + 2) bus.valid = 1'b0;
      if (tx !== exp[k / DIV]) bad[k / DIV]++;
      if (bus.ready !== 1'b0) rbad++;
      if (k / DIV >= 1 && k / DIV <= 8 && k % DIV == DIV / 2) rx[k / DIV - 1] = tx;
    end
    for (int b = 0; b < NBITS; b++)
      check($sformatf("%s slot %0d wrong-level cycles", name, b), bad[b], 0);
    check($sformatf("%s ready high during frame", name), rbad, 0);
    check($sformatf("%s decoded byte", name), int'(rx), int'(exp_byte));
    @(negedge clk);
    check($sformatf("%s ready at E+%0d", name, FR), int'(bus.ready), 1);
    if (drop) begin
      idle_bad = 0;
      for (int k = 0; k < 3 * DIV; k++) begin
        @(negedge clk);
        if (tx !== 1'b1 || bus.ready !== 1'b1) idle_bad++;
      end
      check($sformatf("%s no extra frame", name), idle_bad, 0);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame8n1;
    bit         hold;
    logic [7:0] nxt;
    bit         mid;
  } vec_t;

  initial begin
    vec_t vec[7];
    logic [10:0] exp;
    logic [7:0] cur, nxt;
    bit hold, prev_hold;
    int bad, ok;

    vec[0] = '{8'h40, 10'h280, 1'b0, 8'h00, 1'b0};
    vec[1] = '{8'h61, 10'h2C2, 1'b1, 8'h93, 1'b0};
    vec[2] = '{8'h93, 10'h326, 1'b1, 8'h29, 1'b0};
    vec[3] = '{8'h29, 10'h252, 1'b1, 8'h49, 1'b0};
    vec[4] = '{8'h49, 10'h292, 1'b1, 8'h19, 1'b0};
    vec[5] = '{8'h19, 10'h232, 1'b0, 8'h00, 1'b0};
    vec[6] = '{8'h93, 10'h326, 1'b0, 8'hFF, 1'b1};

    // Reset held for 5 cycles, then a long quiet line
    rst_n = 1'b0;
    bus.valid = 1'b0;
    bus.data = 8'h00;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.ready !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("reset outputs", bad, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.ready !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("idle after reset", bad, 0);

    // Table: single byte, back-to-back chain, data/valid abuse
    for (int i = 0; i < 7; i++) begin
      if (i == 0 || !vec[i - 1].hold) begin
        bus.data = vec[i].data;
        bus.valid = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      exp = {1'b1, ^vec[i].frame8n1[8:1], vec[i].frame8n1[8:0]};
`else
      exp = {1'b1, vec[i].frame8n1};
`endif
      run_frame(exp, vec[i].data, !vec[i].hold, vec[i].nxt, vec[i].mid,
                $sformatf("vec%0d", i));
    end

    // Reset during data bit 3 of 0x55, then a clean 0xA5
    bus.data = 8'h55;
    bus.valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 4 * FR; t++) begin
      if (bus.ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("rst-mid accept", ok, 1);
    for (int k = 0; k <= 4 * DIV + 5; k++) begin
      @(negedge clk);
      if (k == 0) bus.valid = 1'b0;
    end
    check("rst-mid bit3 level", int'(tx), 0);
    rst_n = 1'b0;
    #1;
    check("rst-mid async tx", int'(tx), 1);
    check("rst-mid async ready", int'(bus.ready), 1);
    last_held = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus.ready !== 1'b1) bad++;
    end
    check("rst-mid no resume", bad, 0);
    bus.data = 8'hA5;
    bus.valid = 1'b1;
`ifdef UART_TX_PARITY_EN
    exp = {1'b1, 1'b0, 9'h14A};
`else
    exp = {1'b1, 10'h34A};
`endif
    run_frame(exp, 8'hA5, 1'b1, 8'h00, 1'b0, "after-reset A5");

    // Random bytes, random back-to-back chains and idle gaps
    prev_hold = 1'b0;
    cur = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      nxt = 8'($urandom);
      hold = (i < 9) && ($urandom_range(0, 1) == 1);
      if (!prev_hold) begin
        bus.data = cur;
        bus.valid = 1'b1;
      end
      run_frame(line_frame(cur), cur, !hold, nxt, 1'b0, $sformatf("rand%0d", i));
      if (!hold) begin
        for (int g = 0; g < int'($urandom_range(0, 20)); g++) @(negedge clk);
        cur = 8'($urandom);
      end else begin
        cur = nxt;
      end
      prev_hold = hold;
    end

    check("busy equals !ready violations", busy_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
